// File: rtl/srio_nwr_arbiter.sv
// Round-robin owner of the single SRIO NWRITE user interface, one packet per grant.
// Optional WAIT_DONE watchdog enabled by defining SRIO_NWR_ARB_TIMEOUT_EN.
module srio_nwr_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int IDX_W          = 2,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                    log_clk,
   input  logic                    log_rst,
   input  logic [NUM_REQ-1:0]      req_i,
   input  logic [34*NUM_REQ-1:0]   req_addr_i,
   input  logic [20*NUM_REQ-1:0]   req_tsize_i,
   input  logic [64*NUM_REQ-1:0]   src_tdata_i,
   input  logic [NUM_REQ-1:0]      src_tvalid_i,
   input  logic [8*NUM_REQ-1:0]    src_tkeep_i,
   input  logic [NUM_REQ-1:0]      src_tlast_i,
   output logic [NUM_REQ-1:0]      src_tready_o,
   input  logic                    nwr_ready_in,
   input  logic                    nwr_busy_in,
   input  logic                    nwr_done_in,
   input  logic                    user_tready_in,
   output logic [33:0]             user_addr_o,
   output logic [19:0]             user_tsize_o,
   output logic [63:0]             user_tdata_o,
   output logic                    user_tvalid_o,
   output logic [7:0]              user_tkeep_o,
   output logic                    user_tlast_o,
   output logic                    user_tfirst_o,
   output logic [NUM_REQ-1:0]      grant_o,
   output logic [NUM_REQ-1:0]      done_o,
   output logic                    err_o
);

   typedef enum logic [1:0] {IDLE, XFER, WAIT_DONE} state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] grant_idx, rr_ptr, win_idx, cand_idx;
   logic             win_vld;
   logic             first_flag;
   logic             xfer, beat_acc, last_acc, start, finish, timeout;
   int               cand;

   // Pick the first requester at or above the round-robin pointer.
   always_comb begin
      win_idx  = '0;
      win_vld  = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand     = (int'(rr_ptr) + i) % NUM_REQ;
         cand_idx = IDX_W'(cand);
         if (!win_vld && req_i[cand_idx]) begin
            win_vld = 1'b1;
            win_idx = cand_idx;
         end
      end
   end

   assign xfer     = (state == XFER);
   assign beat_acc = xfer && src_tvalid_i[grant_idx] && user_tready_in;
   assign last_acc = beat_acc && src_tlast_i[grant_idx];
   assign start    = (state == IDLE) && nwr_ready_in && !nwr_busy_in && win_vld;
   assign finish   = (state == WAIT_DONE) && (nwr_done_in || timeout);

   always_comb begin
      src_tready_o = '0;
      if (xfer) src_tready_o[grant_idx] = user_tready_in;
   end

   assign user_tvalid_o = xfer && src_tvalid_i[grant_idx];
   assign user_tlast_o  = xfer && src_tlast_i[grant_idx];
   assign user_tdata_o  = xfer ? src_tdata_i[grant_idx*64 +: 64] : '0;
   assign user_tkeep_o  = xfer ? src_tkeep_i[grant_idx*8 +: 8] : '0;
   assign user_tfirst_o = user_tvalid_o && first_flag;

   always_ff @(posedge log_clk or posedge log_rst) begin
      if (log_rst) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (start)    state_nxt = XFER;
         XFER:      if (last_acc) state_nxt = WAIT_DONE;
         WAIT_DONE: if (finish)   state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge log_clk or posedge log_rst) begin
      if (log_rst) begin
         grant_idx    <= '0;
         grant_o      <= '0;
         done_o       <= '0;
         rr_ptr       <= '0;
         first_flag   <= 1'b1;
         user_addr_o  <= '0;
         user_tsize_o <= '0;
      end else begin
         done_o <= '0;
         if (start) begin
            grant_idx          <= win_idx;
            grant_o            <= '0;
            grant_o[win_idx]   <= 1'b1;
            user_addr_o        <= req_addr_i[win_idx*34 +: 34];
            user_tsize_o       <= req_tsize_i[win_idx*20 +: 20];
         end
         if (finish) begin
            done_o[grant_idx] <= 1'b1;
            grant_o           <= '0;
            rr_ptr            <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         // A tlast beat re-arms the flag so the next packet starts with tfirst.
         if (beat_acc) first_flag <= last_acc;
      end
   end

`ifdef SRIO_NWR_ARB_TIMEOUT_EN
   logic [31:0] to_cnt;

   assign timeout = (state == WAIT_DONE) && (to_cnt == 32'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge log_clk or posedge log_rst) begin
      if (log_rst) begin
         to_cnt <= '0;
         err_o  <= 1'b0;
      end else begin
         to_cnt <= (state == WAIT_DONE) ? to_cnt + 32'd1 : 32'd0;
         err_o  <= timeout && !nwr_done_in;
      end
   end
`else
   assign timeout = 1'b0;
   assign err_o   = 1'b0;
`endif

endmodule
